fpu_double_sched: RTL
=====================

# fpu_double_sched

Sequencer and round-robin arbiter that shares one `fpu_double` instance between `NUM_REQ` requesters. Each request carries an op, rounding mode and two 64-bit operands. The block issues it to the FPU with the start pulse discipline `fpu_double` requires, waits for completion, and returns the result and exception flags with the requester index on a single response channel. It sits between the FPU issue logic and `fpu_double`, and is the only driver of the FPU's `enable`/operand inputs.

## Interface
- `NUM_REQ`, default 4: number of requesters, ≥2.
- `TIMEOUT_CYCLES`, default 127: watchdog limit, in cycles, counted from the first `fpu_enable` high cycle.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  NUM_REQ  per-requester request valid; request fields held stable while valid.
- `req_ready`  out  NUM_REQ  one-hot grant/accept; a request transfers on `req_valid[i] & req_ready[i]`.
- `req_op`  in  4*NUM_REQ  packed op, requester i at [4i+3:4i].
- `req_rmode`  in  2*NUM_REQ  packed rounding mode.
- `req_opa`, `req_opb`  in  64*NUM_REQ  packed operands.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accept.
- `rsp_id`  out  $clog2(NUM_REQ)  index of the served requester.
- `rsp_data`  out  64  FPU result.
- `rsp_flags`  out  5  {invalid, exception, inexact, overflow, underflow}.
- `rsp_timeout`  out  1  watchdog fired; `rsp_data`/`rsp_flags` are 0.
- `busy`  out  1  state ≠ IDLE.
- `fpu_enable`  out  1  to `fpu_double.enable`.
- `fpu_op`  out  4  to `fpu_double.fpu_op`.
- `fpu_rmode`  out  2  to `fpu_double.rmode`.
- `fpu_opa`, `fpu_opb`  out  64  to `fpu_double.opa`/`opb`.
- `fpu_out`  in  64  from `fpu_double.out`.
- `fpu_ready`  in  1  from `fpu_double.ready`.
- `fpu_flags`  in  5  `fpu_double` flags, same order as `rsp_flags`.

## Operation
- **FSM states:** IDLE → LAUNCH → WAIT_CLR → WAIT_DONE → RESP → IDLE.
- **IDLE:** if any `req_valid`, assert `req_ready` combinationally for the round-robin winner. The search starts at pointer `ptr` and takes the lowest index ≥ `ptr` with valid, wrapping. On transfer:
  - capture op/rmode/opa/opb and id into registers;
  - `ptr` ← (winner+1) mod NUM_REQ;
  - → LAUNCH.
- **LAUNCH:** `fpu_enable` ← 1 (registered); → WAIT_CLR.
- **WAIT_CLR:** hold `fpu_enable` = 1. When `fpu_ready` = 0 → WAIT_DONE. A high `fpu_ready` here is stale from the previous op and is never treated as completion.
- **WAIT_DONE:** hold `fpu_enable` = 1. When `fpu_ready` = 1:
  - capture `fpu_out`/`fpu_flags`;
  - `fpu_enable` ← 0;
  - → RESP.
- **RESP:** `rsp_valid` = 1, all response fields stable until `rsp_ready`; then → IDLE. No grant is issued in RESP.
- **FPU inputs:** `fpu_op`/`fpu_rmode`/`fpu_opa`/`fpu_opb` come only from the capture registers and change only on an IDLE transfer. `fpu_double` samples `fpu_op` late, so these must stay constant through WAIT_DONE.
- **Ops:** passed through unchecked. Codes other than 0–3 and 5 complete normally with whatever `fpu_double` returns.
- **Enable gap:** `fpu_enable` is low in RESP and IDLE, so there are ≥2 low cycles between ops and the FPU always sees a fresh rising edge.
- **Reset (`rst`):** asynchronously, mid-operation included:
  - state IDLE, `ptr` 0;
  - all capture registers and every output 0 (`req_ready`, `rsp_*`, `busy`, `fpu_*`).
  
  No response is issued for an in-flight op.

## Timing
- Cycle 0: transfer in IDLE.
- Cycle 1: LAUNCH (`fpu_enable` rises at the end of cycle 1).
- Response latency: `rsp_valid` rises the cycle after `fpu_ready` is first sampled high in WAIT_DONE.
- Zero-wait response: if `rsp_ready` is high when `rsp_valid` rises, RESP lasts 1 cycle. The next grant is possible in the following IDLE cycle.
- Throughput: one op in flight; minimum overhead 4 cycles per op beyond the FPU's own latency.
- Simultaneous `req_valid` on all inputs with `ptr` = k: grant order k, k+1, … wrapping.

## Configuration
- Macro `FPU_SCHED_WATCHDOG_EN`.
- **Defined:** a counter clears on LAUNCH and increments in WAIT_CLR/WAIT_DONE. On reaching `TIMEOUT_CYCLES`:
  - → RESP with `rsp_timeout` = 1, `rsp_data` = 0, `rsp_flags` = 0;
  - `fpu_enable` ← 0.
- **Undefined:** no counter, `rsp_timeout` tied 0, and the block waits indefinitely for `fpu_ready`.

## Structure
- Package `fpu_sched_pkg`:
  - state enum;
  - flag bit-index constants (FLAG_UF=0 … FLAG_INV=4);
  - op code constants (OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3, OP_SGNJ=5).
- Sub-module `fpu_sched_rr_arb`: combinational round-robin winner from `req_valid` and `ptr`, producing a one-hot grant and an index. The pointer register stays in the top level.

## Test plan
- **Single add:** requester 2 issues op 0, 0x3FF0000000000000 + 0x4000000000000000 → `rsp_id` 2, `rsp_data` 0x4008000000000000, `rsp_flags` 0.
- **Mul:** 0x4018000000000000 × 0x3FE0000000000000, rmode 0 → 0x4008000000000000. `fpu_op` is stable from LAUNCH to RESP.
- **Fairness:** all 4 `req_valid` held high from reset for 8 ops → `rsp_id` sequence 0,1,2,3,0,1,2,3.
- **Backpressure:** `rsp_ready` low for 10 cycles → response fields stable, `req_ready` all 0, `fpu_enable` 0 throughout.
- **Stale ready:** FPU model keeps `fpu_ready` = 1 into the next launch and drops it 2 cycles later → no response until `fpu_ready` falls and rises again.
- **Watchdog and reset:** with `FPU_SCHED_WATCHDOG_EN`, a model that never raises `fpu_ready` → `rsp_timeout` = 1 exactly `TIMEOUT_CYCLES` cycles after LAUNCH. Separately, `rst` asserted in WAIT_DONE → all outputs 0 immediately, and the next request is served normally.

Source files
------------

// File: rtl/fpu_sched_pkg.sv
// Shared types and constants for the fpu_double scheduler.
package fpu_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_CLR  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RESP      = 3'd4
  } state_t;

  localparam int unsigned FLAG_UF  = 0;
  localparam int unsigned FLAG_OF  = 1;
  localparam int unsigned FLAG_INE = 2;
  localparam int unsigned FLAG_EXC = 3;
  localparam int unsigned FLAG_INV = 4;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_SGNJ = 4'd5;

endpackage

// File: rtl/fpu_double_sched_if.sv
// Request/response channel between FPU issue logic (master) and the scheduler (slave).
interface fpu_double_sched_if #(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [4*NUM_REQ-1:0]  req_op;
  logic [2*NUM_REQ-1:0]  req_rmode;
  logic [64*NUM_REQ-1:0] req_opa;
  logic [64*NUM_REQ-1:0] req_opb;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [63:0]           rsp_data;
  logic [4:0]            rsp_flags;
  logic                  rsp_timeout;

  modport master (
    output req_valid, req_op, req_rmode, req_opa, req_opb, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_flags, rsp_timeout
  );

  modport slave (
    input  req_valid, req_op, req_rmode, req_opa, req_opb, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_flags, rsp_timeout
  );
endinterface

// File: rtl/fpu_sched_rr_arb.sv
// Combinational round-robin pick: lowest valid index at or above i_ptr, wrapping.
module fpu_sched_rr_arb #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [IDW-1:0]     i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDW-1:0]     o_idx,
  output logic               o_any
);

  int unsigned w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_j     = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_j = 32'(i_ptr) + i;
      if (w_j >= NUM_REQ) w_j = w_j - NUM_REQ;
      if (!o_any && i_valid[w_j]) begin
        o_any        = 1'b1;
        o_idx        = IDW'(w_j);
        o_grant[w_j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_double_sched.sv
// Round-robin sequencer sharing one fpu_double between NUM_REQ requesters.
// Optional watchdog: define FPU_SCHED_WATCHDOG_EN.
module fpu_double_sched
  import fpu_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 127
) (
  input  logic               clk,
  input  logic               rst,
  fpu_double_sched_if.slave  bus,
  output logic               busy,
  output logic               fpu_enable,
  output logic [3:0]         fpu_op,
  output logic [1:0]         fpu_rmode,
  output logic [63:0]        fpu_opa,
  output logic [63:0]        fpu_opb,
  input  logic [63:0]        fpu_out,
  input  logic               fpu_ready,
  input  logic [4:0]         fpu_flags
);

  localparam int unsigned IDW = $clog2(NUM_REQ);

  state_t             r_state;
  logic [IDW-1:0]     r_ptr;
  logic [IDW-1:0]     r_id;
  logic [3:0]         r_op;
  logic [1:0]         r_rmode;
  logic [63:0]        r_opa;
  logic [63:0]        r_opb;
  logic               r_enable;
  logic [63:0]        r_data;
  logic [4:0]         r_flags;

  logic [NUM_REQ-1:0] w_grant;
  logic [IDW-1:0]     w_idx;
  logic               w_any;
  logic               w_wd_fire;
  logic [3:0]         w_sel_op;
  logic [1:0]         w_sel_rmode;
  logic [63:0]        w_sel_opa;
  logic [63:0]        w_sel_opb;

  fpu_sched_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .i_valid (bus.req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_sel_op    = bus.req_op[32'(w_idx)*4 +: 4];
  assign w_sel_rmode = bus.req_rmode[32'(w_idx)*2 +: 2];
  assign w_sel_opa   = bus.req_opa[32'(w_idx)*64 +: 64];
  assign w_sel_opb   = bus.req_opb[32'(w_idx)*64 +: 64];

  // Grant is gated by rst so req_ready is 0 while reset is held, not just after it.
  assign bus.req_ready = (r_state == S_IDLE && !rst) ? w_grant : '0;
  assign bus.rsp_valid = (r_state == S_RESP);
  assign bus.rsp_id    = r_id;
  assign bus.rsp_data  = r_data;
  assign bus.rsp_flags = r_flags;
  assign busy          = (r_state != S_IDLE);
  assign fpu_enable    = r_enable;
  assign fpu_op        = r_op;
  assign fpu_rmode     = r_rmode;
  assign fpu_opa       = r_opa;
  assign fpu_opb       = r_opb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_id     <= '0;
      r_op     <= '0;
      r_rmode  <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_enable <= 1'b0;
      r_data   <= '0;
      r_flags  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_id    <= w_idx;
            r_op    <= w_sel_op;
            r_rmode <= w_sel_rmode;
            r_opa   <= w_sel_opa;
            r_opb   <= w_sel_opb;
            r_ptr   <= (32'(w_idx) == NUM_REQ - 1) ? '0 : w_idx + 1'b1;
            r_state <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_enable <= 1'b1;
          r_state  <= S_WAIT_CLR;
        end
        // A ready still high here belongs to the previous op; wait for it to drop.
        S_WAIT_CLR: begin
          if (w_wd_fire) begin
            r_data   <= '0;
            r_flags  <= '0;
            r_enable <= 1'b0;
            r_state  <= S_RESP;
          end else if (!fpu_ready) begin
            r_state <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (fpu_ready) begin
            r_data   <= fpu_out;
            r_flags  <= fpu_flags;
            r_enable <= 1'b0;
            r_state  <= S_RESP;
          end else if (w_wd_fire) begin
            r_data   <= '0;
            r_flags  <= '0;
            r_enable <= 1'b0;
            r_state  <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef FPU_SCHED_WATCHDOG_EN
  localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WDW-1:0] r_wd;
  logic           r_timeout;

  // Fires on the TIMEOUT_CYCLES-th enable-high cycle; a same-cycle completion wins.
  assign w_wd_fire = (r_state == S_WAIT_CLR || (r_state == S_WAIT_DONE && !fpu_ready)) &&
                     (r_wd == WDW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else if (r_state == S_LAUNCH) begin
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else if (w_wd_fire) begin
      r_timeout <= 1'b1;
    end else if (r_state == S_WAIT_CLR || r_state == S_WAIT_DONE) begin
      r_wd <= r_wd + 1'b1;
    end
  end

  assign bus.rsp_timeout = r_timeout;
`else
  logic w_unused_cfg;
  assign w_unused_cfg    = (TIMEOUT_CYCLES != 0);
  assign w_wd_fire       = 1'b0;
  assign bus.rsp_timeout = 1'b0;
`endif

endmodule
